// File: rtl/frame_draw_sequencer.sv
// -----------------------------------------------------------------------------
// frame_draw_sequencer
//
// Per-frame draw sequencer that sits between the frame-rate source and the
// draw engine / pixel buffer controller. On each frame tick (while enabled) it
// clears the back buffer, draws up to MAX_TRI triangles from a host-written
// list, then requests a buffer swap and waits for the swap acknowledge.
//
// Ports
//   sys_clk, reset          clock; synchronous active-high reset
//   enable                  1 = frame ticks start frames
//   tri_wr_en/idx/data      host write port into the triangle list
//                           data = {ax,ay,bx,by,cx,cy,colour}, ax in MSBs
//   tri_count               triangles per frame, sampled at frame start
//   opcode                  0 = clear, 1 = triangle
//   ax..cy, colour          vertex / colour operands for the draw engine
//   drawer_en, drawer_done  start pulse / completion pulse of the draw engine
//   buffer_addr             back-buffer base offset for the SDRAM interface
//   swap_buffer, swap_ack   swap request pulse / swap completion
//   busy                    sequencer is inside a frame
//   frame_count             completed frames (wrapping)
//   dropped_count           ticks lost to overrun (saturating)
// -----------------------------------------------------------------------------
module frame_draw_sequencer #(
   parameter int                 COORD_W      = 16,
   parameter int                 COLOUR_W     = 32,
   parameter int                 ADDR_W       = 32,
   parameter int                 MAX_TRI      = 8,
   parameter int                 FRAME_TICKS  = 2383333,
   parameter logic [ADDR_W-1:0]  BUF0_ADDR    = ADDR_W'(32'h0000_0000),
   parameter logic [ADDR_W-1:0]  BUF1_ADDR    = ADDR_W'(32'h0012_C000),
   parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
   localparam int                IDX_W        = (MAX_TRI > 1) ? $clog2(MAX_TRI) : 1,
   localparam int                TRI_W        = 6 * COORD_W + COLOUR_W
) (
   input  logic                sys_clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                tri_wr_en,
   input  logic [IDX_W-1:0]    tri_wr_idx,
   input  logic [TRI_W-1:0]    tri_wr_data,
   input  logic [IDX_W:0]      tri_count,
   output logic [3:0]          opcode,
   output logic [COORD_W-1:0]  ax,
   output logic [COORD_W-1:0]  ay,
   output logic [COORD_W-1:0]  bx,
   output logic [COORD_W-1:0]  by,
   output logic [COORD_W-1:0]  cx,
   output logic [COORD_W-1:0]  cy,
   output logic [COLOUR_W-1:0] colour,
   output logic                drawer_en,
   input  logic                drawer_done,
   output logic [ADDR_W-1:0]   buffer_addr,
   output logic                swap_buffer,
   input  logic                swap_ack,
   output logic                busy,
   output logic [15:0]         frame_count,
   output logic [15:0]         dropped_count
);

   localparam int             CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [IDX_W:0] MAX_N = (IDX_W + 1)'(MAX_TRI);
   localparam logic [IDX_W:0] ONE_N = (IDX_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR_GO,
      S_CLEAR_WAIT,
      S_LOAD,
      S_TRI_GO,
      S_TRI_WAIT,
      S_SWAP,
      S_SWAP_WAIT
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic [IDX_W:0]       n_q, n_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [3:0]           opcode_q, opcode_d;
   logic [COORD_W-1:0]   ax_q, ax_d, ay_q, ay_d, bx_q, bx_d;
   logic [COORD_W-1:0]   by_q, by_d, cx_q, cx_d, cy_q, cy_d;
   logic [COLOUR_W-1:0]  colour_q, colour_d;
   logic                 drawer_en_q, drawer_en_d;
   logic [ADDR_W-1:0]    buffer_addr_q, buffer_addr_d;
   logic                 swap_buffer_q, swap_buffer_d;
   logic                 busy_q, busy_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic [15:0]          dropped_count_q, dropped_count_d;

   // Triangle list storage; contents deliberately survive reset.
   logic [TRI_W-1:0]     tri_mem_q [MAX_TRI];
   logic [TRI_W-1:0]     tri_rd;
   logic [COORD_W-1:0]   rd_ax, rd_ay, rd_bx, rd_by, rd_cx, rd_cy;
   logic [COLOUR_W-1:0]  rd_colour;
   logic                 tick;
   logic                 last_tri;

   always_ff @(posedge sys_clk) begin
      if (tri_wr_en && ({1'b0, tri_wr_idx} < MAX_N)) begin
         tri_mem_q[tri_wr_idx] <= tri_wr_data;
      end
   end

   assign tri_rd = tri_mem_q[idx_q];
   assign {rd_ax, rd_ay, rd_bx, rd_by, rd_cx, rd_cy, rd_colour} = tri_rd;

   assign tick     = (tick_cnt_q == CNT_W'(FRAME_TICKS - 1));
   assign last_tri = ({1'b0, idx_q} == (n_q - ONE_N));

   always_comb begin
      state_d         = state_q;
      tick_cnt_d      = tick ? '0 : tick_cnt_q + CNT_W'(1);
      n_d             = n_q;
      idx_d           = idx_q;
      opcode_d        = opcode_q;
      ax_d            = ax_q;
      ay_d            = ay_q;
      bx_d            = bx_q;
      by_d            = by_q;
      cx_d            = cx_q;
      cy_d            = cy_q;
      colour_d        = colour_q;
      drawer_en_d     = 1'b0;
      buffer_addr_d   = buffer_addr_q;
      swap_buffer_d   = 1'b0;
      frame_count_d   = frame_count_q;
      dropped_count_d = dropped_count_q;

      // A tick arriving while any frame is in flight is lost, including the
      // cycle in which the frame is just finishing in S_SWAP_WAIT.
      if (tick && enable && (state_q != S_IDLE)) begin
         dropped_count_d = sat_inc16(dropped_count_q);
      end

      case (state_q)
         S_IDLE: begin
            if (tick && enable) begin
               n_d     = (tri_count > MAX_N) ? MAX_N : tri_count;
               idx_d   = '0;
               state_d = S_CLEAR_GO;
            end
         end
         S_CLEAR_GO: begin
            opcode_d    = 4'd0;
            colour_d    = CLEAR_COLOUR;
            drawer_en_d = 1'b1;
            state_d     = S_CLEAR_WAIT;
         end
         S_CLEAR_WAIT: begin
            if (drawer_done) begin
               state_d = (n_q == '0) ? S_SWAP : S_LOAD;
            end
         end
         S_LOAD: begin
            // The start pulse is launched together with the vertex load so the
            // engine sees drawer_en in S_TRI_GO alongside the fresh operands,
            // keeping done-to-next-start at two cycles.
            ax_d        = rd_ax;
            ay_d        = rd_ay;
            bx_d        = rd_bx;
            by_d        = rd_by;
            cx_d        = rd_cx;
            cy_d        = rd_cy;
            colour_d    = rd_colour;
            opcode_d    = 4'd1;
            drawer_en_d = 1'b1;
            state_d     = S_TRI_GO;
         end
         S_TRI_GO: begin
            state_d = S_TRI_WAIT;
         end
         S_TRI_WAIT: begin
            if (drawer_done) begin
               if (last_tri) begin
                  state_d = S_SWAP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_LOAD;
               end
            end
         end
         S_SWAP: begin
            swap_buffer_d = 1'b1;
            buffer_addr_d = (buffer_addr_q == BUF1_ADDR) ? BUF0_ADDR : BUF1_ADDR;
            state_d       = S_SWAP_WAIT;
         end
         S_SWAP_WAIT: begin
            if (swap_ack) begin
               frame_count_d = frame_count_q + 16'd1;
               state_d       = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         tick_cnt_q      <= '0;
         n_q             <= '0;
         idx_q           <= '0;
         opcode_q        <= 4'd0;
         ax_q            <= '0;
         ay_q            <= '0;
         bx_q            <= '0;
         by_q            <= '0;
         cx_q            <= '0;
         cy_q            <= '0;
         colour_q        <= '0;
         drawer_en_q     <= 1'b0;
         buffer_addr_q   <= BUF1_ADDR;
         swap_buffer_q   <= 1'b0;
         busy_q          <= 1'b0;
         frame_count_q   <= 16'd0;
         dropped_count_q <= 16'd0;
      end else begin
         state_q         <= state_d;
         tick_cnt_q      <= tick_cnt_d;
         n_q             <= n_d;
         idx_q           <= idx_d;
         opcode_q        <= opcode_d;
         ax_q            <= ax_d;
         ay_q            <= ay_d;
         bx_q            <= bx_d;
         by_q            <= by_d;
         cx_q            <= cx_d;
         cy_q            <= cy_d;
         colour_q        <= colour_d;
         drawer_en_q     <= drawer_en_d;
         buffer_addr_q   <= buffer_addr_d;
         swap_buffer_q   <= swap_buffer_d;
         busy_q          <= busy_d;
         frame_count_q   <= frame_count_d;
         dropped_count_q <= dropped_count_d;
      end
   end

   assign opcode        = opcode_q;
   assign ax            = ax_q;
   assign ay            = ay_q;
   assign bx            = bx_q;
   assign by            = by_q;
   assign cx            = cx_q;
   assign cy            = cy_q;
   assign colour        = colour_q;
   assign drawer_en     = drawer_en_q;
   assign buffer_addr   = buffer_addr_q;
   assign swap_buffer   = swap_buffer_q;
   assign busy          = busy_q;
   assign frame_count   = frame_count_q;
   assign dropped_count = dropped_count_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_sequencer
//
// Scoreboard bench: each frame request pushes the expected clear / triangle /
// swap events into a queue; a monitor pops and compares whenever the DUT
// raises drawer_en or swap_buffer. Draw-engine and swap responders are modelled
// with configurable delays.
// -----------------------------------------------------------------------------
module tb_frame_draw_sequencer;

   localparam logic [31:0] BUF0 = 32'h0000_0000;
   localparam logic [31:0] BUF1 = 32'h0012_C000;

   typedef struct packed {
      logic         is_swap;
      logic [3:0]   opcode;
      logic [127:0] payload;
      logic [31:0]  addr;
      logic [15:0]  fc;
   } exp_t;

   logic         sys_clk;
   logic         reset;
   logic         enable;
   logic         tri_wr_en;
   logic [2:0]   tri_wr_idx;
   logic [127:0] tri_wr_data;
   logic [3:0]   tri_count;
   logic [3:0]   opcode;
   logic [15:0]  ax, ay, bx, by, cx, cy;
   logic [31:0]  colour;
   logic         drawer_en;
   logic         drawer_done;
   logic [31:0]  buffer_addr;
   logic         swap_buffer;
   logic         swap_ack;
   logic         busy;
   logic [15:0]  frame_count;
   logic [15:0]  dropped_count;

   exp_t         exp_q[$];
   logic [127:0] list_m [8];
   logic [31:0]  exp_buf = BUF1;
   logic [15:0]  frames_model = 16'd0;
   logic [15:0]  drop_before;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           busy_rise_cyc = 0;
   int           last_done_cyc = 0;
   int           swap_cyc = 0;
   int           done_delay = 1;
   int           ack_delay = 0;
   bit           spurious = 1'b0;
   bit           busy_prev = 1'b0;

   frame_draw_sequencer #(
      .COORD_W     (16),
      .COLOUR_W    (32),
      .ADDR_W      (32),
      .MAX_TRI     (8),
      .FRAME_TICKS (100),
      .BUF0_ADDR   (BUF0),
      .BUF1_ADDR   (BUF1),
      .CLEAR_COLOUR(32'h0)
   ) dut (
      .sys_clk      (sys_clk),
      .reset        (reset),
      .enable       (enable),
      .tri_wr_en    (tri_wr_en),
      .tri_wr_idx   (tri_wr_idx),
      .tri_wr_data  (tri_wr_data),
      .tri_count    (tri_count),
      .opcode       (opcode),
      .ax           (ax),
      .ay           (ay),
      .bx           (bx),
      .by           (by),
      .cx           (cx),
      .cy           (cy),
      .colour       (colour),
      .drawer_en    (drawer_en),
      .drawer_done  (drawer_done),
      .buffer_addr  (buffer_addr),
      .swap_buffer  (swap_buffer),
      .swap_ack     (swap_ack),
      .busy         (busy),
      .frame_count  (frame_count),
      .dropped_count(dropped_count)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Draw-engine responder: one done pulse per start, optionally preceded by
   // a spurious done in the cycle the start pulse is visible.
   initial begin : engine
      drawer_done = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (drawer_en) begin
            if (spurious && opcode == 4'd1) begin
               drawer_done = 1'b1;
               @(negedge sys_clk);
               drawer_done = 1'b0;
            end else begin
               @(negedge sys_clk);
            end
            repeat (done_delay - 1) @(negedge sys_clk);
            drawer_done   = 1'b1;
            last_done_cyc = cyc;
            @(negedge sys_clk);
            drawer_done = 1'b0;
         end
      end
   end

   // Pixel-buffer-controller responder.
   initial begin : swapper
      swap_ack = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (swap_buffer) begin
            repeat (ack_delay) @(negedge sys_clk);
            swap_ack = 1'b1;
            @(negedge sys_clk);
            swap_ack = 1'b0;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge sys_clk);
         if (busy && !busy_prev) busy_rise_cyc = cyc;
         busy_prev = busy;
         if (drawer_en || swap_buffer) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_event: drawer_en=%0b swap_buffer=%0b opcode=%0d, expected none",
                        drawer_en, swap_buffer, opcode);
            end else begin
               e = exp_q.pop_front();
               if (swap_buffer) begin
                  swap_cyc = cyc;
                  chk("swap_event", {1'b1, buffer_addr, frame_count}, {e.is_swap, e.addr, e.fc});
               end else if (opcode == 4'd0) begin
                  chk("clear_event", {1'b0, opcode, colour}, {e.is_swap, e.opcode, e.payload[31:0]});
                  chk("busy_to_clear_en", cyc - busy_rise_cyc, 1);
               end else begin
                  chk("tri_event", {1'b0, opcode, ax, ay, bx, by, cx, cy, colour},
                      {e.is_swap, e.opcode, e.payload});
                  chk("done_to_tri_en", cyc - last_done_cyc, 2);
               end
            end
         end
      end
   end

   task automatic write_tri(input int idx, input logic [127:0] data);
      tri_wr_en   = 1'b1;
      tri_wr_idx  = 3'(idx);
      tri_wr_data = data;
      list_m[idx] = data;
      @(negedge sys_clk);
      tri_wr_en = 1'b0;
   endtask

   task automatic push_frame(input int n);
      exp_t e;
      int   m;
      m = (n > 8) ? 8 : n;
      e = '0;
      exp_q.push_back(e);
      for (int i = 0; i < m; i++) begin
         e         = '0;
         e.opcode  = 4'd1;
         e.payload = list_m[i];
         exp_q.push_back(e);
      end
      exp_buf   = (exp_buf == BUF1) ? BUF0 : BUF1;
      e         = '0;
      e.is_swap = 1'b1;
      e.addr    = exp_buf;
      e.fc      = frames_model;
      exp_q.push_back(e);
      frames_model = frames_model + 16'd1;
   endtask

   task automatic wait_frame(input int bound, input int ack_lat);
      int k = 0;
      while (frame_count !== frames_model && k < bound) begin
         @(negedge sys_clk);
         k++;
      end
      chk("frame_done", frame_count, frames_model);
      chk("swap_to_frame_done", cyc - swap_cyc, ack_lat);
   endtask

   task automatic wait_busy(input int bound);
      int k = 0;
      while (!busy && k < bound) begin
         @(negedge sys_clk);
         k++;
      end
   endtask

   initial begin : stimulus
      int k;
      reset       = 1'b1;
      enable      = 1'b0;
      tri_wr_en   = 1'b0;
      tri_wr_idx  = '0;
      tri_wr_data = '0;
      tri_count   = '0;
      repeat (3) @(negedge sys_clk);

      chk("reset_ctrl", {busy, drawer_en, swap_buffer, opcode}, 7'd0);
      chk("reset_buffer_addr", buffer_addr, BUF1);
      chk("reset_counters", {frame_count, dropped_count}, 32'd0);
      chk("reset_operands", {ax, ay, bx, by, cx, cy, colour}, 128'd0);
      reset = 1'b0;
      @(negedge sys_clk);

      // Empty list: clear then swap.
      tri_count = 4'd0;
      push_frame(0);
      enable = 1'b1;
      wait_frame(400, 1);
      enable = 1'b0;

      // Two listed triangles.
      write_tri(0, {16'd100, 16'd100, 16'd150, 16'd100, 16'd100, 16'd150, 32'hFFFF_0000});
      write_tri(1, {16'd0, 16'd0, 16'd639, 16'd0, 16'd0, 16'd479, 32'h0000_FFFF});
      tri_count = 4'd2;
      push_frame(2);
      enable = 1'b1;
      wait_frame(400, 1);
      enable = 1'b0;

      // Count above MAX_TRI clamps to 8; tri_count change mid-frame ignored.
      for (int i = 2; i < 8; i++) begin
         write_tri(i, {16'(10 * i), 16'(10 * i + 1), 16'(10 * i + 2), 16'(10 * i + 3),
                       16'(10 * i + 4), 16'(10 * i + 5), 32'hC0DE_0000 + 32'(i)});
      end
      tri_count = 4'd12;
      push_frame(12);
      enable = 1'b1;
      wait_busy(300);
      tri_count = 4'd1;
      wait_frame(400, 1);
      enable = 1'b0;

      // Spurious done in S_TRI_GO, delayed ack, enable dropped mid-frame.
      tri_count  = 4'd2;
      spurious   = 1'b1;
      done_delay = 3;
      ack_delay  = 30;
      push_frame(2);
      enable = 1'b1;
      wait_busy(300);
      enable = 1'b0;
      wait_frame(400, 31);
      chk("busy_after_frame", busy, 1'b0);
      spurious   = 1'b0;
      done_delay = 1;
      ack_delay  = 0;

      // Clear held off 250 cycles: two ticks lost.
      tri_count   = 4'd0;
      done_delay  = 250;
      drop_before = dropped_count;
      push_frame(0);
      enable = 1'b1;
      wait_frame(600, 1);
      enable = 1'b0;
      chk("overrun_dropped", dropped_count, drop_before + 16'd2);
      done_delay = 1;

      // Ack lands on the tick cycle: that tick is dropped.
      ack_delay   = 95;
      drop_before = dropped_count;
      push_frame(0);
      enable = 1'b1;
      wait_frame(400, 96);
      enable = 1'b0;
      chk("tick_on_ack_dropped", dropped_count, drop_before + 16'd1);
      chk("tick_on_ack_idle", busy, 1'b0);
      ack_delay = 0;

      // Reset while waiting on a triangle.
      tri_count  = 4'd2;
      done_delay = 20;
      push_frame(2);
      enable = 1'b1;
      k = 0;
      while (!(drawer_en && opcode == 4'd1) && k < 300) begin
         @(negedge sys_clk);
         k++;
      end
      @(negedge sys_clk);
      reset = 1'b1;
      @(negedge sys_clk);
      chk("midreset_ctrl", {busy, drawer_en, swap_buffer}, 3'd0);
      chk("midreset_buffer_addr", buffer_addr, BUF1);
      chk("midreset_counters", {frame_count, dropped_count}, 32'd0);
      reset  = 1'b0;
      enable = 1'b0;
      exp_q.delete();
      frames_model = 16'd0;
      exp_buf      = BUF1;
      repeat (40) @(negedge sys_clk);
      done_delay = 1;

      // Recovery frame after reset.
      tri_count = 4'd1;
      push_frame(1);
      enable = 1'b1;
      wait_frame(400, 1);
      enable = 1'b0;
      repeat (5) @(negedge sys_clk);

      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
